sys_array: RTL and testbench
============================

SYS_ARRAY -- requirements
Module: sys_array

Interface
REQ-001 Parameter: row_width, default 8, N = rows = columns of the square processing-element (PE) grid.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 active  input  1  valid tag; enters every row at column 0.
REQ-005 data_in  input  4N  4-bit unsigned activation per row; nibble r feeds row r (nibble 0 is row 0).
REQ-006 w_in  input  4N  4-bit unsigned weight per column; nibble c feeds column c top.
REQ-007 sum_in  input  8N  8-bit partial sum per column; byte c enters column c top.
REQ-008 weight_wren  input  N  per-column weight shift enable.
REQ-009 mac_out  output  8N  byte c = bottom-row partial sum of column c.
REQ-010 w_out  output  4N  nibble c = bottom-row weight register of column c.
REQ-011 weight_wren_out  output  N  weight_wren registered once.
REQ-012 active_out  output  N  bit r = active tag leaving the right edge of row r.
REQ-013 data_out  output  4N  nibble r = data register of PE(r,N-1).

Function
REQ-014 Each PE(r,c) shall hold 4-bit w_reg, 4-bit d_reg, 1-bit a_reg, 8-bit s_reg.
REQ-015 d_left: data_in[r] for c=0, else d_reg of PE(r,c-1); a_left likewise from active / a_reg.
REQ-016 s_up: sum_in[c] for r=0, else s_reg of PE(r-1,c); w_up: w_in[c] for r=0, else w_reg of PE(r-1,c).
REQ-017 Every edge: d_reg <= d_left; a_reg <= a_left; s_reg <= s_up + d_left*w_reg (4x4 unsigned product, 8 bits).
REQ-018 Accumulation shall wrap modulo 256 (default build).
REQ-019 Edge with weight_wren[c]=1: every w_reg in column c shifts down (w_reg <= w_up); the bottom value is discarded. With weight_wren[c]=0, weights hold.
REQ-020 After N consecutive load edges, row r holds the w_in value presented at load edge N-1-r. The first value presented ends in the bottom row.
REQ-021 active is a tag only and shall not gate arithmetic. active_out[r] = a_reg of PE(r,N-1), so it lags active by N edges.
REQ-022 Latency: data_in[r] sampled at edge k contributes to mac_out[c] after edge k+c+(N-1-r). sum_in[c] reaches mac_out[c] after N edges.
REQ-023 With row-skewed input (row r delayed r cycles), column c result appears N+c edges after the row-0 sample.
REQ-024 Loading weights while data flows is legal. A PE uses its w_reg value before the edge.
REQ-025 All outputs shall be driven directly from registers, with no combinational input-to-output path.

Reset
REQ-026 rst=1 at an edge shall clear every w_reg, d_reg, a_reg, s_reg and weight_wren_out. All outputs read 0 the cycle after.
REQ-027 rst shall take priority over weight_wren and data movement. Reset mid-operation discards all weights and partial sums.

Configuration
REQ-028 Macro SYS_ARRAY_SAT_EN defined: each PE add shall saturate at 255 (unsigned 9-bit sum clamped). Undefined: wrap per REQ-018.

Verification
REQ-029 Reset: rst high one edge after arbitrary activity -> mac_out=0, w_out=0, active_out=0, data_out=0, weight_wren_out=0.
REQ-030 Weight load, N=8: weight_wren=8'hFF for 8 edges, w_in rows 1..8 = all-nibbles 1..8 -> w_out=all 1s; bottom row weight 1, top row weight 8; weight_wren_out=8'hFF one edge behind.
REQ-031 All weights 1, skewed data 1 on every row, sum_in=0 -> mac_out[c]=8 exactly N+c edges after the row-0 sample; idle elsewhere = 0.
REQ-032 All weights 0, sum_in byte c = 0x12 -> mac_out[c]=0x12 after 8 edges.
REQ-033 All weights 15, skewed data 15, sum_in=0 -> mac_out[c]=8 (1800 mod 256). With SYS_ARRAY_SAT_EN -> 255.
REQ-034 active pulsed 1 cycle -> active_out all bits high for exactly one cycle, N edges later. Data pattern 5 on row 3 -> data_out nibble 3 = 5 after N edges.

Source files
------------

// File: rtl/sys_array.sv
// Square grid of 4x4-bit MAC cells: activations move right, partial sums and weights move down.
// Build option SYS_ARRAY_SAT_EN: each cell's accumulate clamps at 255 instead of wrapping.

module sys_array_pe (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_left,
  input  logic       a_left,
  input  logic [7:0] s_up,
  input  logic [3:0] w_up,
  input  logic       wren,
  output logic [3:0] d_q,
  output logic       a_q,
  output logic [7:0] s_q,
  output logic [3:0] w_q
);
  logic [3:0] d_d, w_d;
  logic       a_d;
  logic [7:0] s_d, prod;
`ifdef SYS_ARRAY_SAT_EN
  logic [8:0] sum;
`else
  logic [7:0] sum;
`endif

  always_comb begin
    // product uses the weight held before this edge, even while a new one shifts in
    prod = {4'b0, d_left} * {4'b0, w_q};
`ifdef SYS_ARRAY_SAT_EN
    sum  = {1'b0, s_up} + {1'b0, prod};
    s_d  = sum[8] ? 8'hFF : sum[7:0];
`else
    sum  = s_up + prod;
    s_d  = sum;
`endif
    d_d = d_left;
    a_d = a_left;
    w_d = wren ? w_up : w_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
      a_q <= 1'b0;
      s_q <= '0;
      w_q <= '0;
    end else begin
      d_q <= d_d;
      a_q <= a_d;
      s_q <= s_d;
      w_q <= w_d;
    end
  end
endmodule

module sys_array #(
  parameter int row_width = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   active,
  input  logic [4*row_width-1:0] data_in,
  input  logic [4*row_width-1:0] w_in,
  input  logic [8*row_width-1:0] sum_in,
  input  logic [row_width-1:0]   weight_wren,
  output logic [8*row_width-1:0] mac_out,
  output logic [4*row_width-1:0] w_out,
  output logic [row_width-1:0]   weight_wren_out,
  output logic [row_width-1:0]   active_out,
  output logic [4*row_width-1:0] data_out
);
  localparam int N = row_width;

  // grid indices are [row][col]
  logic [N-1:0][N-1:0][3:0] d_g, w_g;
  logic [N-1:0][N-1:0][7:0] s_g;
  logic [N-1:0][N-1:0]      a_g;
  logic [N-1:0]             wren_out_d, wren_out_q;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [3:0] d_l, w_u;
      logic       a_l;
      logic [7:0] s_u;

      if (c == 0) begin : g_left_edge
        assign d_l = data_in[4*r +: 4];
        assign a_l = active;
      end else begin : g_left_pe
        assign d_l = d_g[r][c-1];
        assign a_l = a_g[r][c-1];
      end

      if (r == 0) begin : g_top_edge
        assign s_u = sum_in[8*c +: 8];
        assign w_u = w_in[4*c +: 4];
      end else begin : g_top_pe
        assign s_u = s_g[r-1][c];
        assign w_u = w_g[r-1][c];
      end

      sys_array_pe u_pe (
        .clk    (clk),
        .rst    (rst),
        .d_left (d_l),
        .a_left (a_l),
        .s_up   (s_u),
        .w_up   (w_u),
        .wren   (weight_wren[c]),
        .d_q    (d_g[r][c]),
        .a_q    (a_g[r][c]),
        .s_q    (s_g[r][c]),
        .w_q    (w_g[r][c])
      );
    end
  end

  always_comb begin
    wren_out_d = weight_wren;
  end

  always_ff @(posedge clk) begin
    if (rst) wren_out_q <= '0;
    else     wren_out_q <= wren_out_d;
  end

  for (genvar i = 0; i < N; i++) begin : g_out
    assign mac_out[8*i +: 8]  = s_g[N-1][i];
    assign w_out[4*i +: 4]    = w_g[N-1][i];
    assign data_out[4*i +: 4] = d_g[i][N-1];
    assign active_out[i]      = a_g[i][N-1];
  end

  assign weight_wren_out = wren_out_q;
endmodule

// File: tb/tb_sys_array.sv
// Randomized self-checking bench for sys_array: history-based latency model plus fixed spec vectors.
module tb_sys_array;
  localparam int N  = 8;
  localparam int HL = 4096;

  logic             clk = 1'b0;
  logic             rst, active;
  logic [4*N-1:0]   data_in, w_in, w_out, data_out;
  logic [8*N-1:0]   sum_in, mac_out;
  logic [N-1:0]     weight_wren, weight_wren_out, active_out;

  sys_array #(.row_width(N)) dut (
    .clk(clk), .rst(rst), .active(active), .data_in(data_in), .w_in(w_in),
    .sum_in(sum_in), .weight_wren(weight_wren), .mac_out(mac_out), .w_out(w_out),
    .weight_wren_out(weight_wren_out), .active_out(active_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // input history per edge number, plus column weight stacks (row 0 = most recent load)
  logic [3:0]   dh [0:HL-1][0:N-1];
  logic [7:0]   sh [0:HL-1][0:N-1];
  logic         ah [0:HL-1];
  logic [N-1:0] wrh [0:HL-1];
  logic [3:0]   wh [0:HL-1][0:N-1][0:N-1];
  logic [3:0]   wcur [0:N-1][0:N-1];
  int t = 0, rst_t = 0;
  int n_cmp = 0, n_bad = 0;

  task automatic step();
    @(posedge clk);
    t++;
    for (int r = 0; r < N; r++) dh[t][r] = data_in[4*r +: 4];
    for (int c = 0; c < N; c++) sh[t][c] = sum_in[8*c +: 8];
    ah[t]  = active;
    wrh[t] = weight_wren;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wh[t][r][c] = wcur[r][c];
    if (rst) begin
      rst_t = t;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) wcur[r][c] = 4'd0;
    end else begin
      for (int c = 0; c < N; c++)
        if (weight_wren[c]) begin
          for (int r = N-1; r > 0; r--) wcur[r][c] = wcur[r-1][c];
          wcur[0][c] = w_in[4*c +: 4];
        end
    end
    #1;
  endtask

  function automatic logic [3:0] d_at(int e, int r);
    return (e <= rst_t) ? 4'd0 : dh[e][r];
  endfunction

  // column result after edge t: sum_in from N-1 edges ago, then each row's product in turn
  function automatic logic [8*N-1:0] exp_mac();
    logic [8*N-1:0] m;
    for (int c = 0; c < N; c++) begin
      int s = 0;
      for (int r = 0; r < N; r++) begin
        int e = t - (N-1-r);
        if (e <= rst_t) s = 0;
        else begin
          if (r == 0) s = int'(sh[e][c]);
          s = s + int'(d_at(e-c, r)) * int'(wh[e][r][c]);
`ifdef SYS_ARRAY_SAT_EN
          if (s > 255) s = 255;
`else
          s = s % 256;
`endif
        end
      end
      m[8*c +: 8] = 8'(s);
    end
    return m;
  endfunction

  function automatic logic [4*N-1:0] exp_dout();
    logic [4*N-1:0] v;
    for (int r = 0; r < N; r++) v[4*r +: 4] = d_at(t-(N-1), r);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_aout();
    int e = t - (N-1);
    return (e <= rst_t) ? '0 : {N{ah[e]}};
  endfunction

  function automatic logic [4*N-1:0] exp_wout();
    logic [4*N-1:0] v;
    for (int c = 0; c < N; c++) v[4*c +: 4] = wcur[N-1][c];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_wwo();
    return (t <= rst_t) ? '0 : wrh[t];
  endfunction

  task automatic drive_random(input bit with_wren);
    data_in     = {$urandom, $urandom};
    w_in        = $urandom;
    sum_in      = {$urandom, $urandom};
    active      = 1'($urandom);
    weight_wren = with_wren ? N'($urandom) : '0;
  endtask

  task automatic load_weights(input logic [3:0] v);
    rst = 1'b0; active = 1'b0; data_in = '0; sum_in = '0;
    weight_wren = '1; w_in = {N{v}};
    for (int i = 0; i < N; i++) step();
    weight_wren = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; active = 1'b0; data_in = '0; w_in = '0; sum_in = '0; weight_wren = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin drive_random(1'b1); step(); end
    drive_random(1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp += 5;
    if (mac_out !== '0) begin n_bad++; $display("FAIL reset_mac got %h want 0", mac_out); end
    if (w_out !== '0) begin n_bad++; $display("FAIL reset_wout got %h want 0", w_out); end
    if (active_out !== '0) begin n_bad++; $display("FAIL reset_aout got %h want 0", active_out); end
    if (data_out !== '0) begin n_bad++; $display("FAIL reset_dout got %h want 0", data_out); end
    if (weight_wren_out !== '0) begin n_bad++; $display("FAIL reset_wwo got %h want 0", weight_wren_out); end
  endtask

  task automatic test_weight_load();
    int k0;
    rst = 1'b0; active = 1'b0; data_in = '0; sum_in = '0; weight_wren = '1;
    for (int k = 1; k <= N; k++) begin
      w_in = {N{4'(k)}};
      step();
      n_cmp += 2;
      if (weight_wren_out !== '1) begin n_bad++; $display("FAIL load_wwo got %h want ff", weight_wren_out); end
      if (w_out !== exp_wout()) begin n_bad++; $display("FAIL load_wout got %h want %h", w_out, exp_wout()); end
    end
    n_cmp++;
    if (w_out !== {N{4'h1}}) begin n_bad++; $display("FAIL load_bottom got %h want %h", w_out, {N{4'h1}}); end
    weight_wren = '0;
    step();
    n_cmp++;
    if (weight_wren_out !== '0) begin n_bad++; $display("FAIL load_wwo_off got %h want 0", weight_wren_out); end
    // top row holds 8: a single 1 on row 0 yields 8 down every column
    data_in = '0; data_in[3:0] = 4'd1;
    step();
    k0 = t;
    data_in = '0;
    for (int i = 0; i < 2*N; i++) begin
      step();
      for (int c = 0; c < N; c++) begin
        logic [7:0] want = (t == k0 + N-1 + c) ? 8'd8 : 8'd0;
        n_cmp++;
        if (mac_out[8*c +: 8] !== want) begin
          n_bad++; $display("FAIL top_row_w c=%0d got %h want %h", c, mac_out[8*c +: 8], want);
        end
      end
    end
  endtask

  task automatic test_skewed_mac(input logic [3:0] wv, input logic [3:0] dv, input logic [7:0] want);
    int k0;
    load_weights(wv);
    for (int i = 0; i < N; i++) step();
    k0 = t + 1;
    for (int i = 0; i < 2*N + 2; i++) begin
      for (int r = 0; r < N; r++) data_in[4*r +: 4] = (i == r) ? dv : 4'd0;
      step();
      for (int c = 0; c < N; c++) begin
        logic [7:0] w8 = (t == k0 + N-1 + c) ? want : 8'd0;
        n_cmp++;
        if (mac_out[8*c +: 8] !== w8) begin
          n_bad++; $display("FAIL skew_w%0d c=%0d t=%0d got %h want %h", wv, c, t, mac_out[8*c +: 8], w8);
        end
      end
      n_cmp++;
      if (mac_out !== exp_mac()) begin n_bad++; $display("FAIL skew_model got %h want %h", mac_out, exp_mac()); end
    end
  endtask

  task automatic test_zero_weights();
    load_weights(4'd0);
    sum_in = {N{8'h12}};
    for (int i = 1; i <= N; i++) begin
      data_in = {$urandom, $urandom};
      step();
      n_cmp++;
      if (mac_out !== exp_mac()) begin n_bad++; $display("FAIL zero_w_model got %h want %h", mac_out, exp_mac()); end
    end
    n_cmp++;
    if (mac_out !== {N{8'h12}}) begin n_bad++; $display("FAIL zero_w_pass got %h want %h", mac_out, {N{8'h12}}); end
    sum_in = '0; data_in = '0;
  endtask

  task automatic test_active();
    int k;
    rst = 1'b0; weight_wren = '0; sum_in = '0;
    data_in = '0; data_in[15:12] = 4'd5;
    active = 1'b1;
    step();
    k = t;
    active = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      logic [N-1:0] want;
      step();
      want = (t == k + N-1) ? '1 : '0;
      n_cmp++;
      if (active_out !== want) begin n_bad++; $display("FAIL active_pulse t=%0d got %h want %h", t, active_out, want); end
    end
    n_cmp += 2;
    if (data_out[15:12] !== 4'd5) begin n_bad++; $display("FAIL dout_row3 got %h want 5", data_out[15:12]); end
    if (data_out !== exp_dout()) begin n_bad++; $display("FAIL dout_model got %h want %h", data_out, exp_dout()); end
  endtask

  task automatic test_random();
    rst = 1'b0; active = 1'b0; data_in = '0; sum_in = '0; weight_wren = '1;
    for (int i = 0; i < N; i++) begin w_in = $urandom; step(); end
    for (int i = 0; i < 150; i++) begin
      drive_random(1'b0);
      step();
      n_cmp += 4;
      if (mac_out !== exp_mac()) begin n_bad++; $display("FAIL rand_mac got %h want %h", mac_out, exp_mac()); end
      if (data_out !== exp_dout()) begin n_bad++; $display("FAIL rand_dout got %h want %h", data_out, exp_dout()); end
      if (active_out !== exp_aout()) begin n_bad++; $display("FAIL rand_aout got %h want %h", active_out, exp_aout()); end
      if (w_out !== exp_wout()) begin n_bad++; $display("FAIL rand_wout got %h want %h", w_out, exp_wout()); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 150; i++) begin
      drive_random(1'b1);
      step();
      n_cmp += 3;
      if (mac_out !== exp_mac()) begin n_bad++; $display("FAIL b2b_mac got %h want %h", mac_out, exp_mac()); end
      if (w_out !== exp_wout()) begin n_bad++; $display("FAIL b2b_wout got %h want %h", w_out, exp_wout()); end
      if (weight_wren_out !== exp_wwo()) begin n_bad++; $display("FAIL b2b_wwo got %h want %h", weight_wren_out, exp_wwo()); end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 30; i++) begin drive_random(1'b1); step(); end
    drive_random(1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp += 2;
    if (mac_out !== '0) begin n_bad++; $display("FAIL midrst_mac got %h want 0", mac_out); end
    if (w_out !== '0) begin n_bad++; $display("FAIL midrst_wout got %h want 0", w_out); end
    for (int i = 0; i < 30; i++) begin
      drive_random(1'b1);
      step();
      n_cmp += 3;
      if (mac_out !== exp_mac()) begin n_bad++; $display("FAIL midrst_model got %h want %h", mac_out, exp_mac()); end
      if (data_out !== exp_dout()) begin n_bad++; $display("FAIL midrst_dout got %h want %h", data_out, exp_dout()); end
      if (active_out !== exp_aout()) begin n_bad++; $display("FAIL midrst_aout got %h want %h", active_out, exp_aout()); end
    end
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_skewed_mac(4'd1, 4'd1, 8'd8);
`ifdef SYS_ARRAY_SAT_EN
    test_skewed_mac(4'd15, 4'd15, 8'd255);
`else
    test_skewed_mac(4'd15, 4'd15, 8'd8);
`endif
    test_zero_weights();
    test_active();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
